// File: rtl/jtsdram_bank_arb.sv
// jtsdram_bank_arb: round-robin arbiter sharing one SDRAM command port
// between four bank requesters (bank 0 read/write, banks 1-3 read-only).
// Grant latency 1 cycle from a pending request in IDLE. Requesters are held
// off by keeping req_ack low until the controller accepts. Refresh requests
// block new grants only.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_addr[4*AW], req_rd[4]     per-bank address and read request (level)
//   ba0_wr, ba0_din, ba0_din_m    bank 0 write request, data, byte-disable mask
//   req_ack[4], req_rdy[4]        per-bank accept / data-done pulses
//   sdram_*                       command side towards the SDRAM controller
//   rfsh_req, refresh_en          refresh window request / permission
//   busy, err                     grant open / sticky timeout flag
module jtsdram_bank_arb #(
   parameter int AW   = 22,
   parameter int TOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4*AW-1:0] req_addr,
   input  logic [3:0]      req_rd,
   input  logic            ba0_wr,
   input  logic [15:0]     ba0_din,
   input  logic [1:0]      ba0_din_m,
   output logic [3:0]      req_ack,
   output logic [3:0]      req_rdy,
   output logic [AW-1:0]   sdram_addr,
   output logic [1:0]      sdram_ba,
   output logic            sdram_rd,
   output logic            sdram_wr,
   output logic [15:0]     sdram_din,
   output logic [1:0]      sdram_din_m,
   input  logic            sdram_ack,
   input  logic            sdram_rdy,
   input  logic            rfsh_req,
   output logic            refresh_en,
   output logic            busy,
   output logic            err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // Abort fires on the edge where the counter would reach TOUT, so a grant
   // stays open for exactly TOUT cycles.
   localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

   logic [1:0]    state;
   logic [1:0]    ptr;
   logic [7:0]    cnt;
   logic [3:0]    pend;
   logic [1:0]    pick;
   logic [1:0]    idx;
   logic          pick_vld;
   logic          pick_wr;
   logic [AW-1:0] pick_addr;
   logic          tout_hit;

   // Rotating priority: scan from the farthest candidate back to ptr so the
   // nearest pending bank (starting at ptr) is the last, winning assignment.
   always_comb begin
      pend     = req_rd | {3'b000, ba0_wr};
      pick     = ptr;
      pick_vld = 1'b0;
      idx      = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (pend[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
      // Bank 0 write wins over its own read; the read stays pending.
      pick_wr   = (pick == 2'd0) && ba0_wr;
      pick_addr = req_addr[int'(pick)*AW +: AW];
   end

   assign tout_hit   = (cnt == TOUT_LAST);
   // Gated by rst_n so refresh is never offered while the arbiter is held in reset.
   assign refresh_en = rst_n && (state == ST_IDLE) && rfsh_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ptr         <= 2'd0;
         cnt         <= 8'd0;
         req_ack     <= 4'b0;
         req_rdy     <= 4'b0;
         sdram_addr  <= '0;
         sdram_ba    <= 2'd0;
         sdram_rd    <= 1'b0;
         sdram_wr    <= 1'b0;
         sdram_din   <= 16'd0;
         sdram_din_m <= 2'd0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         req_ack <= 4'b0;
         req_rdy <= 4'b0;
         case (state)
            ST_IDLE: begin
               if (!rfsh_req && pick_vld) begin
                  state       <= ST_CMD;
                  sdram_ba    <= pick;
                  sdram_addr  <= pick_addr;
                  sdram_wr    <= pick_wr;
                  sdram_rd    <= !pick_wr;
                  sdram_din   <= ba0_din;
                  sdram_din_m <= ba0_din_m;
                  cnt         <= 8'd0;
                  busy        <= 1'b1;
               end
            end
            ST_CMD, ST_DATA: begin
               cnt <= cnt + 8'd1;
               // sdram_ba holds the granted bank for the life of the grant.
               if (tout_hit) begin
                  err <= 1'b1;
                  if (state == ST_CMD) req_ack[sdram_ba] <= 1'b1;
                  req_rdy[sdram_ba] <= 1'b1;
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  sdram_rd <= 1'b0;
                  sdram_wr <= 1'b0;
                  ptr      <= sdram_ba + 2'd1;
               end else if (state == ST_CMD) begin
                  if (sdram_ack) begin
                     req_ack[sdram_ba] <= 1'b1;
                     sdram_rd <= 1'b0;
                     sdram_wr <= 1'b0;
                     if (sdram_rdy) begin
                        req_rdy[sdram_ba] <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ptr   <= sdram_ba + 2'd1;
                     end else begin
                        state <= ST_DATA;
                     end
                  end
               end else if (sdram_rdy) begin
                  req_rdy[sdram_ba] <= 1'b1;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  ptr   <= sdram_ba + 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtsdram_bank_arb.sv
// Testbench for jtsdram_bank_arb: directed scenarios plus a randomized phase.
// Expected grants come from a transaction-level round-robin model.
module tb_jtsdram_bank_arb;

   localparam int AW   = 22;
   localparam int TOUT = 255;

   logic            clk;
   logic            rst_n;
   logic [4*AW-1:0] req_addr;
   logic [3:0]      req_rd;
   logic            ba0_wr;
   logic [15:0]     ba0_din;
   logic [1:0]      ba0_din_m;
   logic [3:0]      req_ack;
   logic [3:0]      req_rdy;
   logic [AW-1:0]   sdram_addr;
   logic [1:0]      sdram_ba;
   logic            sdram_rd;
   logic            sdram_wr;
   logic [15:0]     sdram_din;
   logic [1:0]      sdram_din_m;
   logic            sdram_ack;
   logic            sdram_rdy;
   logic            rfsh_req;
   logic            refresh_en;
   logic            busy;
   logic            err;

   int checks = 0;
   int errors = 0;
   int mptr   = 0;   // model round-robin pointer
   int last_g = -1;  // bank of the most recent grant
   bit last_w = 0;   // most recent grant was a write

   jtsdram_bank_arb #(.AW(AW), .TOUT(TOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_addr(req_addr), .req_rd(req_rd),
      .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
      .req_ack(req_ack), .req_rdy(req_rdy),
      .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
      .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
      .sdram_din(sdram_din), .sdram_din_m(sdram_din_m),
      .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
      .rfsh_req(rfsh_req), .refresh_en(refresh_en),
      .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Outputs are sampled and inputs driven on the falling edge.
   task automatic nxt();
      @(negedge clk);
   endtask

   // Round-robin rule: first pending bank at or after mptr, modulo 4.
   function automatic void model_pick(output int g, output bit w);
      logic [3:0] p;
      p = req_rd | {3'b000, ba0_wr};
      g = 0;
      for (int k = 3; k >= 0; k--) begin
         if (p[(mptr + k) % 4]) g = (mptr + k) % 4;
      end
      w = (g == 0) && ba0_wr;
   endfunction

   // Raise new requests on idle banks; addresses/data change only when not pending.
   task automatic rand_reqs();
      for (int b = 0; b < 4; b++) begin
         bit pb;
         pb = req_rd[b] || (b == 0 && ba0_wr);
         if (!pb && $urandom_range(1, 0) == 1) begin
            req_addr[b*AW +: AW] = AW'($urandom);
            req_rd[b] = 1'b1;
            if (b == 0 && $urandom_range(1, 0) == 1) begin
               ba0_wr    = 1'b1;
               ba0_din   = 16'($urandom);
               ba0_din_m = 2'($urandom);
            end
         end
      end
      if (req_rd == 4'b0 && !ba0_wr) req_rd[3] = 1'b1;
   endtask

   // One full grant. Called in the IDLE cycle with a non-empty pending set.
   // ad: cycles from strobe to sdram_ack; rd: cycles from ack-sample to
   // sdram_rdy, or -1 for ack and rdy in the same cycle.
   task automatic do_grant(input int ad, input int rd, input bit keep, input bit rnd, input bit rf);
      int g;
      bit w;
      logic [3:0] oh;
      model_pick(g, w);
      oh = 4'(1 << g);
      last_g = g;
      last_w = w;
      nxt();
      chk("strobe_rd", sdram_rd, !w);
      chk("strobe_wr", sdram_wr, w);
      chk("grant_ba", sdram_ba, g);
      chk("grant_addr", sdram_addr, req_addr[g*AW +: AW]);
      chk("grant_busy", busy, 1);
      chk("grant_no_pulse", {req_ack, req_rdy}, 0);
      if (w) begin
         chk("wr_din", sdram_din, ba0_din);
         chk("wr_mask", sdram_din_m, ba0_din_m);
      end
      repeat (ad) begin
         nxt();
         chk("strobe_hold", sdram_rd | sdram_wr, 1);
         chk("ack_early", req_ack, 0);
      end
      sdram_ack = 1'b1;
      if (rd < 0) sdram_rdy = 1'b1;
      nxt();
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      chk("req_ack", req_ack, oh);
      chk("strobe_drop", sdram_rd | sdram_wr, 0);
      if (!keep) begin
         if (w) ba0_wr = 1'b0;
         else   req_rd[g] = 1'b0;
      end
      if (rnd) rand_reqs();
      if (rd >= 0) begin
         chk("rdy_early", req_rdy, 0);
         if (rf) begin
            rfsh_req = 1'b1;
            #1;
            chk("rfsh_blocked_data", refresh_en, 0);
         end
         repeat (rd) begin
            nxt();
            chk("data_busy", busy, 1);
            chk("ack_one_cycle", req_ack, 0);
            if (rf) chk("rfsh_blocked_wait", refresh_en, 0);
         end
         sdram_rdy = 1'b1;
         nxt();
         sdram_rdy = 1'b0;
         chk("req_rdy", req_rdy, oh);
         chk("ack_gone", req_ack, 0);
         if (rf) chk("rfsh_after_rdy", refresh_en, 1);
      end else begin
         chk("req_rdy_same", req_rdy, oh);
      end
      chk("idle_busy", busy, 0);
      mptr = (g + 1) % 4;
   endtask

   int order[5] = '{0, 1, 2, 3, 0};
   int n;

   initial begin
      rst_n     = 1'b0;
      req_addr  = '0;
      req_rd    = 4'b0;
      ba0_wr    = 1'b0;
      ba0_din   = 16'd0;
      ba0_din_m = 2'd0;
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      rfsh_req  = 1'b1;
      #2;
      // Reset state
      chk("rst_ack", req_ack, 0);
      chk("rst_rdy", req_rdy, 0);
      chk("rst_strobes", {sdram_rd, sdram_wr}, 0);
      chk("rst_addr", sdram_addr, 0);
      chk("rst_ba", sdram_ba, 0);
      chk("rst_din", {sdram_din, sdram_din_m}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_refresh_en", refresh_en, 0);
      nxt();
      nxt();
      rst_n    = 1'b1;
      rfsh_req = 1'b0;

      // All four banks requesting continuously from ptr=0
      for (int b = 0; b < 4; b++) req_addr[b*AW +: AW] = AW'($urandom);
      req_rd = 4'hF;
      for (int i = 0; i < 5; i++) begin
         do_grant(1, 1, 1, 0, 0);
         chk("rr_order", last_g, order[i]);
      end
      req_rd = 4'b0;

      // Single read of bank 2
      req_addr[2*AW +: AW] = 22'h12345;
      req_rd = 4'b0100;
      do_grant(2, 2, 0, 0, 0);
      chk("single_ba", last_g, 2);
      chk("single_err", err, 0);

      // Bank 0 write wins over its own read
      req_addr[0 +: AW] = AW'($urandom);
      ba0_wr    = 1'b1;
      ba0_din   = 16'hA55A;
      ba0_din_m = 2'b01;
      req_rd    = 4'b0001;
      do_grant(1, 1, 0, 0, 0);
      chk("wr_first", last_w, 1);
      do_grant(0, 0, 0, 0, 0);
      chk("rd_second", last_w, 0);
      chk("rd_second_bank", last_g, 0);

      // Refresh requested while bank 1 is in DATA
      req_rd = 4'b0010;
      do_grant(1, 2, 0, 0, 1);
      req_rd[2] = 1'b1;
      repeat (4) begin
         nxt();
         chk("rfsh_no_strobe", sdram_rd | sdram_wr, 0);
         chk("rfsh_en_idle", refresh_en, 1);
      end
      rfsh_req = 1'b0;
      do_grant(0, 1, 0, 0, 0);
      chk("post_rfsh_bank", last_g, 2);

      // Controller never acks bank 3
      req_rd = 4'b1000;
      nxt();
      chk("tout_strobe", sdram_rd, 1);
      chk("tout_ba", sdram_ba, 3);
      chk("tout_err_before", err, 0);
      req_addr[AW +: AW] = AW'($urandom);
      req_rd[1] = 1'b1;
      n = 0;
      while (req_ack == 4'b0 && n < 400) begin
         nxt();
         n++;
      end
      chk("tout_cycles", n, TOUT);
      chk("tout_err", err, 1);
      chk("tout_ack", req_ack, 4'b1000);
      chk("tout_rdy", req_rdy, 4'b1000);
      chk("tout_busy", busy, 0);
      req_rd[3] = 1'b0;
      mptr = 0;
      do_grant(1, 1, 0, 0, 0);
      chk("tout_next_bank", last_g, 1);
      chk("err_sticky", err, 1);

      // Randomized traffic
      rand_reqs();
      for (int i = 0; i < 40; i++) begin
         int ad;
         int rd;
         ad = int'($urandom_range(3, 0));
         rd = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(3, 0));
         do_grant(ad, rd, 0, 1, 0);
      end
      req_rd = 4'b0;
      ba0_wr = 1'b0;
      chk("err_sticky_end", err, 1);

      // Reset during CMD for bank 1
      nxt();
      req_rd = 4'b0010;
      nxt();
      chk("midrst_strobe", sdram_rd, 1);
      chk("midrst_ba", sdram_ba, 1);
      rfsh_req = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_rd_drop", sdram_rd, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_refresh_en", refresh_en, 0);
      chk("midrst_err_clr", err, 0);
      req_rd = 4'b0;
      mptr = 0;
      nxt();
      rst_n = 1'b1;
      rfsh_req = 1'b0;
      repeat (3) begin
         sdram_ack = 1'b1;
         sdram_rdy = 1'b1;
         nxt();
         chk("idle_ignore_ack", req_ack, 0);
         chk("idle_ignore_rdy", req_rdy, 0);
         chk("idle_no_grant", busy | sdram_rd | sdram_wr, 0);
      end
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      req_rd = 4'hF;
      do_grant(0, 0, 1, 0, 0);
      chk("ptr_after_reset", last_g, 0);
      req_rd = 4'b0;
      nxt();
      nxt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
